elastic_pipeline: RTL and testbench
===================================

Name: elastic_pipeline

Overview:
Parametrised successor to the fixed-delay pipeline register. It carries WIDTH-bit data through STAGES register stages, each with its own valid bit, under valid/ready flow control. Empty stages collapse under backpressure, and a synchronous flush clears all in-flight data. It sits between deepfloat arithmetic units whose consumers can stall, and it replaces hand-counted delay chains.

Parameters:
WIDTH, 8, data width in bits (>=1)
STAGES, 2, number of register stages (>=1); also the minimum latency in cycles

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
init  input  WIDTH  value loaded into every data register on reset
in_valid  input  1  upstream has data on in_data
in_ready  output  1  pipeline accepts in_data this cycle
in_data  input  WIDTH  upstream data
out_valid  output  1  out_data holds a valid item
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  WIDTH  data of the last stage
flush  input  1  synchronous clear of all in-flight items

Behaviour:
- Interface: reset is reset, synchronous, active-high; clock is clock.
- State per stage i (0..STAGES-1): data[i] (WIDTH bits) and v[i] (1 bit). Stage 0 is the input side; stage STAGES-1 drives the outputs.
- Reset: all v[i]=0 and all data[i]=init. Resulting outputs: out_valid=0, out_data=init, in_ready=1 (when flush=0).
- Advance chain (combinational):
  - adv[STAGES-1] = !v[STAGES-1] | out_ready
  - adv[i] = !v[i] | adv[i+1]
  - in_ready = adv[0] & !flush
- The ready path is purely combinational across all stages. There is no ready registering in the base block.
- On each rising edge, when not in reset or flush:
  - If adv[i] is set, then v[i] <= upstream valid, where upstream valid is in_valid for i=0 and v[i-1] otherwise.
  - data[i] loads the upstream data only when adv[i] and the upstream valid are both set. Otherwise data[i] holds, as a power gate.
- A transfer occurs when valid & ready are both high on the same edge, on either side.
- Latency: an item accepted on edge k appears on out_data, with out_valid=1, after edge k+STAGES-1. With out_ready held high, throughput is 1 item/cycle.
- Bubble collapse: a stalled output does not block stages behind an empty stage. Items keep advancing until every stage is full; in_ready falls only when all STAGES stages are valid and out_ready=0.
- Output hold: while out_valid=1 and out_ready=0, out_valid and out_data are stable. This holds regardless of upstream activity.
- Flush:
  - All v[i] are cleared on the edge; data registers hold.
  - in_ready=0 during flush, so nothing is accepted on that edge.
  - out_valid may be 1 during the flush cycle; a downstream handshake in that cycle counts.
- Simultaneous reset and flush: reset wins, and data is loaded with init.
- Reset mid-operation discards all items. The first accept after reset deasserts follows on the next edge.
- STAGES=1: a single full-throughput register slice, with in_ready = !v[0] | out_ready.
- Item order is preserved. No item is duplicated or dropped except by flush or reset.
- Elaboration check: STAGES<1 or WIDTH<1 is a fatal error.

Optional Feature:
Macro ELASTIC_PIPELINE_OCCUPANCY_EN.
- Defined: adds output occupancy, width $clog2(STAGES+1), equal to the popcount of v[] (combinational from registers). It reads 0 after reset or flush and STAGES when full.
- Undefined: the port and its logic are absent. Core behaviour is identical in both builds.

Decomposition:
- No shared package types are needed. Add the localparam OCC_W = $clog2(STAGES+1) locally.
- A generic clog2 helper goes in the shared utils package if one does not already exist.
- One sub-module: elastic_stage (one data register plus valid bit).
  - Inputs: up_valid, up_data, adv, flush, init.
  - Outputs: v, data.
- The top level generates STAGES instances and the advance chain.

Test Plan:
- STAGES=3, out_ready=1, stream 10,11,12 on consecutive edges → outputs 10,11,12 appear 2 edges after their accept edge, back-to-back, with in_ready constantly 1.
- STAGES=3, out_ready=0, push 1,2,3,4 → 1,2,3 accepted and in_ready=0 when 4 is offered. Then raise out_ready → outputs 1,2,3 then 4, in order, out_data stable while stalled.
- Bubble collapse, STAGES=4:
  - Push A, idle 2 cycles, push B, with out_ready=0 → both A and B are held, and in_ready stays 1 until all 4 stages fill.
  - Occupancy reads 2 (feature enabled).
- Flush with 3 items in flight and in_valid=1 → next cycle out_valid=0, occupancy=0, and the flush-cycle input is not accepted.
- Assert reset mid-stream with init=0xA5 → out_valid=0 and out_data=0xA5 after the edge. The next pushed item emerges normally.
- STAGES=1, random in_valid/out_ready for 10k cycles → scoreboard shows an identical, in-order stream with no loss or duplication.

Source files
------------

// File: rtl/elastic_pipeline_pkg.sv
// elastic_pipeline shared utilities.
// Holds a generic clog2 helper for sizing derived widths.
package elastic_pipeline_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/elastic_pipeline_stage.sv
// elastic_stage: one data register plus valid bit.
// Data only loads on a real transfer so idle stages stay quiet.
module elastic_stage
  import elastic_pipeline_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             adv,
  input  logic             flush,
  input  logic [WIDTH-1:0] init,
  output logic             v,
  output logic [WIDTH-1:0] data
);

  // Valid follows upstream when advancing; data gated on valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      v    <= 1'b0;
      data <= init;
    end else if (flush) begin
      v <= 1'b0;
    end else if (adv) begin
      v <= up_valid;
      if (up_valid) data <= up_data;
    end
  end

endmodule

// File: rtl/elastic_pipeline.sv
// elastic_pipeline: STAGES-deep valid/ready register pipeline.
// Define ELASTIC_PIPELINE_OCCUPANCY_EN to add the occupancy output.
module elastic_pipeline
  import elastic_pipeline_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
  ,
  localparam int OCC_W = clog2(STAGES + 1)
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] init,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush
`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
  ,
  output logic [OCC_W-1:0] occupancy
`endif
);

  if (STAGES < 1 || WIDTH < 1) begin : g_bad
    $fatal(1, "elastic_pipeline: STAGES and WIDTH must be >= 1");
  end

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;
  logic [WIDTH-1:0]  data [STAGES];

  // A stage advances if it is empty or anything downstream moves.
  always_comb begin
    logic acc;
    adv = '0;
    acc = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc    = acc | !v[i];
      adv[i] = acc;
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic             up_v;
    logic [WIDTH-1:0] up_d;

    if (i == 0) begin : g_head
      assign up_v = in_valid;
      assign up_d = in_data;
    end else begin : g_body
      assign up_v = v[i-1];
      assign up_d = data[i-1];
    end

    elastic_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clock   (clock),
      .reset   (reset),
      .up_valid(up_v),
      .up_data (up_d),
      .adv     (adv[i]),
      .flush   (flush),
      .init    (init),
      .v       (v[i]),
      .data    (data[i])
    );
  end

  assign in_ready  = adv[0] & !flush;
  assign out_valid = v[STAGES-1];
  assign out_data  = data[STAGES-1];

`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
  // Count of valid stages.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++) begin
      occupancy = occupancy + OCC_W'(v[i]);
    end
  end
`endif

endmodule

// File: tb/tb_elastic_pipeline.sv
// tb_elastic_pipeline: directed and random checks of elastic_pipeline.
// Three instances (3, 4 and 1 stages) share one stimulus stream.
module tb_elastic_pipeline;

  localparam int SD [3] = '{3, 4, 1};

  logic       clock;
  logic       reset;
  logic [7:0] init;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;
  logic       flush;
  logic       ir [3];
  logic       ov [3];
  logic [7:0] od [3];

`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
  logic [1:0] occ0;
  logic [2:0] occ1;
  logic [0:0] occ2;
`endif

  int tests;
  int fails;
  logic [7:0]  got [$];
  logic [39:0] sq [3][$];

  elastic_pipeline #(.WIDTH(8), .STAGES(3)) u_s3 (
    .clock(clock), .reset(reset), .init(init),
    .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .flush(flush)
`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
    , .occupancy(occ0)
`endif
  );

  elastic_pipeline #(.WIDTH(8), .STAGES(4)) u_s4 (
    .clock(clock), .reset(reset), .init(init),
    .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .flush(flush)
`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
    , .occupancy(occ1)
`endif
  );

  elastic_pipeline #(.WIDTH(8), .STAGES(1)) u_s1 (
    .clock(clock), .reset(reset), .init(init),
    .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
    .flush(flush)
`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
    , .occupancy(occ2)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic [7:0] iv);
    @(negedge clock);
    reset     = 1'b1;
    init      = iv;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    flush     = 1'b0;
    out_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic drain(input int d, input int n, input bit offer,
                       input logic [7:0] item);
    bit pend;
    pend = offer;
    got.delete();
    repeat (n) begin
      @(negedge clock);
      out_ready = 1'b1;
      flush     = 1'b0;
      in_valid  = pend;
      in_data   = item;
      #1;
      if (ov[d] && out_ready) got.push_back(od[d]);
      if (in_valid && ir[d]) pend = 1'b0;
    end
  endtask

  initial begin
    int cnt;
    logic [7:0] exp_q [$];
    tests     = 0;
    fails     = 0;
    reset     = 1'b1;
    init      = 8'h00;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    flush     = 1'b0;

    // reset state
    do_reset(8'h5A);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_ov%0d", d), ov[d], 0);
      check($sformatf("rst_od%0d", d), od[d], 8'h5A);
      check($sformatf("rst_ir%0d", d), ir[d], 1);
    end

    // streaming, 3 stages, out_ready high
    do_reset(8'h00);
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      out_ready = 1'b1;
      in_valid  = (c < 3);
      in_data   = 8'(10 + c);
      #1;
      check("stream_ir", ir[0], 1);
      check("stream_ov", ov[0], (c >= 3));
      if (c >= 3) check("stream_od", od[0], 7 + c);
    end

    // backpressure, 3 stages
    do_reset(8'h00);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = (c < 3) ? 8'(c + 1) : 8'd4;
      #1;
      check("bp_ir", ir[0], (c < 3));
      if (c >= 3) begin
        check("bp_hold_ov", ov[0], 1);
        check("bp_hold_od", od[0], 1);
      end
    end
    drain(0, 8, 1'b1, 8'd4);
    exp_q = '{8'd1, 8'd2, 8'd3, 8'd4};
    check("bp_count", got.size(), 4);
    for (int k = 0; k < 4 && k < got.size(); k++)
      check($sformatf("bp_item%0d", k), got[k], exp_q[k]);

    // bubble collapse, 4 stages
    do_reset(8'h00);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      out_ready = 1'b0;
      in_valid  = (c == 0 || c == 3 || c == 7 || c == 8 || c == 9);
      unique case (c)
        0:       in_data = 8'hAA;
        3:       in_data = 8'hBB;
        7:       in_data = 8'hCC;
        8:       in_data = 8'hDD;
        default: in_data = 8'hEE;
      endcase
      #1;
      check("bub_ir", ir[1], (c < 9));
      if (c == 6) begin
        check("bub_ov", ov[1], 1);
        check("bub_od", od[1], 8'hAA);
`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
        check("bub_occ", occ1, 2);
`endif
      end
`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
      if (c == 9) check("bub_occ_full", occ1, 4);
`endif
    end
    drain(1, 10, 1'b1, 8'hEE);
    exp_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    check("bub_count", got.size(), 5);
    for (int k = 0; k < 5 && k < got.size(); k++)
      check($sformatf("bub_item%0d", k), got[k], exp_q[k]);

    // flush with 3 items in flight
    do_reset(8'h00);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'(8'h61 + c);
    end
    @(negedge clock);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    #1;
    check("fl_ir", ir[0], 0);
    check("fl_ov_during", ov[0], 1);
    @(negedge clock);
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("fl_ov_after", ov[0], 0);
    check("fl_ir_after", ir[0], 1);
`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
    check("fl_occ", occ0, 0);
`endif
    cnt = 0;
    repeat (6) begin
      @(negedge clock);
      out_ready = 1'b1;
      #1;
      if (ov[0]) cnt++;
    end
    check("fl_no_leak", cnt, 0);

    // reset in the middle of a stream
    do_reset(8'h00);
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'(8'h11 * (c + 1));
    end
    @(negedge clock);
    reset    = 1'b1;
    init     = 8'hA5;
    in_valid = 1'b1;
    in_data  = 8'h33;
    @(negedge clock);
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h42;
    #1;
    check("mr_ov", ov[0], 0);
    check("mr_od", od[0], 8'hA5);
    check("mr_ir", ir[0], 1);
    for (int c = 1; c < 4; c++) begin
      @(negedge clock);
      in_valid = 1'b0;
      #1;
      check("mr_lat_ov", ov[0], (c == 3));
      check("mr_lat_od", od[0], (c == 3) ? 8'h42 : 8'hA5);
    end

    // random traffic against queue model, all three depths
    do_reset(8'h00);
    for (int d = 0; d < 3; d++) sq[d].delete();
    for (int t = 0; t < 10012; t++) begin
      @(negedge clock);
      if (t < 10000) begin
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = ($urandom_range(0, 3) != 0);
        in_data   = 8'($urandom);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      #1;
      for (int d = 0; d < 3; d++) begin
        check("rnd_ir", ir[d],
              (sq[d].size() < SD[d]) || out_ready);
        if (sq[d].size() == 0) check("rnd_empty_ov", ov[d], 0);
        if (sq[d].size() == SD[d]) check("rnd_full_ov", ov[d], 1);
        if (SD[d] == 1) check("rnd_s1_ov", ov[d], (sq[d].size() != 0));
        if (ov[d] && sq[d].size() != 0) begin
          check("rnd_od", od[d], sq[d][0][7:0]);
          check("rnd_lat", (t - int'(sq[d][0][39:8])) >= SD[d], 1);
        end
        if (ov[d] && out_ready && sq[d].size() != 0)
          void'(sq[d].pop_front());
        if (in_valid && ir[d])
          sq[d].push_back({32'(t), in_data});
      end
    end
    for (int d = 0; d < 3; d++)
      check($sformatf("rnd_drained%0d", d), sq[d].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
